// File: rtl/mem_stage_if.sv
// Handshake and data bundle around the memory stage: upstream bus, data SRAM
// response, downstream bus and the decode bypass.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 194,
  parameter int MS_TO_WS_BUS_WD = 155
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       ws_allowin;
  logic                       ws_cancel;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ms_fwd_valid;
  logic [4:0]                 ms_fwd_dest;
  logic [31:0]                ms_fwd_data;
  logic                       ms_fwd_blk;
  logic                       ms_has_ex;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
           ws_allowin, ws_cancel,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_valid, ms_fwd_dest,
           ms_fwd_data, ms_fwd_blk, ms_has_ex
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
           ws_allowin, ws_cancel,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_valid, ms_fwd_dest,
           ms_fwd_data, ms_fwd_blk, ms_has_ex
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data SRAM response, aligns load data
// (including lwl/lwr merging) and discards responses of flushed requests.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 194,
  parameter int MS_TO_WS_BUS_WD = 155
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave ms_if
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  logic                       r_data_got;
  logic [31:0]                r_data_buf;
  logic [1:0]                 r_discard_cnt;

  logic [81:0] w_pass;
  logic        w_ex;
  logic        w_eret;
  logic        w_res_from_cp0;
  logic        w_res_from_mem;
  logic [2:0]  w_load_op;
  logic [1:0]  w_addr_low;
  logic        w_req_issued;
  logic [31:0] w_rt_value;
  logic [3:0]  w_rf_we_in;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;

  assign w_pass         = r_es_bus[193:112];
  assign w_ex           = r_es_bus[193];
  assign w_eret         = r_es_bus[154];
  assign w_res_from_cp0 = r_es_bus[112];
  assign w_res_from_mem = r_es_bus[111];
  assign w_load_op      = r_es_bus[110:108];
  assign w_addr_low     = r_es_bus[107:106];
  assign w_req_issued   = r_es_bus[105];
  assign w_rt_value     = r_es_bus[104:73];
  assign w_rf_we_in     = r_es_bus[72:69];
  assign w_dest         = r_es_bus[68:64];
  assign w_alu_result   = r_es_bus[63:32];
  assign w_pc           = r_es_bus[31:0];

  logic w_data_ok_live;
  logic w_ready_go;
  logic w_allowin;
  logic w_leave;
  logic w_capture;
  logic w_disc_inc;
  logic w_disc_dec;

  // A beat only belongs to this instruction once all stale beats are drained.
  assign w_data_ok_live = ms_if.data_sram_data_ok & (r_discard_cnt == 2'd0);
  assign w_ready_go     = ~w_req_issued | r_data_got | w_data_ok_live;
  assign w_allowin      = ~r_ms_valid | (w_ready_go & ms_if.ws_allowin);
  assign w_leave        = r_ms_valid & w_ready_go & ms_if.ws_allowin;
  assign w_capture      = w_data_ok_live & r_ms_valid & ~r_data_got;
  assign w_disc_inc     = ms_if.ws_cancel & r_ms_valid & w_req_issued &
                          ~r_data_got & ~w_data_ok_live;
  assign w_disc_dec     = ms_if.data_sram_data_ok & (r_discard_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid    <= 1'b0;
      r_data_got    <= 1'b0;
      r_discard_cnt <= 2'd0;
    end else begin
      if (ms_if.ws_cancel)
        r_ms_valid <= 1'b0;
      else if (w_allowin)
        r_ms_valid <= ms_if.es_to_ms_valid;

      if (ms_if.ws_cancel | w_leave)
        r_data_got <= 1'b0;
      else if (w_capture)
        r_data_got <= 1'b1;

      r_discard_cnt <= r_discard_cnt + {1'b0, w_disc_inc} - {1'b0, w_disc_dec};
    end
  end

  always_ff @(posedge clk) begin
    if (ms_if.es_to_ms_valid & w_allowin)
      r_es_bus <= ms_if.es_to_ms_bus;
    if (w_capture)
      r_data_buf <= ms_if.data_sram_rdata;
  end

  logic [31:0] w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_result;
  logic [3:0]  w_rf_we;

  assign w_load_data = r_data_got ? r_data_buf : ms_if.data_sram_rdata;
  assign w_half      = w_addr_low[1] ? w_load_data[31:16] : w_load_data[15:0];

  always_comb begin
    w_byte = w_load_data[7:0];
    case (w_addr_low)
      2'd0: w_byte = w_load_data[7:0];
      2'd1: w_byte = w_load_data[15:8];
      2'd2: w_byte = w_load_data[23:16];
      2'd3: w_byte = w_load_data[31:24];
      default: w_byte = w_load_data[7:0];
    endcase
  end

  // lwl/lwr merge memory bytes into rt and narrow the byte write enables.
  always_comb begin
    w_load_result = w_load_data;
    w_rf_we       = w_rf_we_in;
    case (w_load_op)
      3'd1: w_load_result = {{24{w_byte[7]}}, w_byte};
      3'd2: w_load_result = {24'd0, w_byte};
      3'd3: w_load_result = {{16{w_half[15]}}, w_half};
      3'd4: w_load_result = {16'd0, w_half};
      3'd5: begin
        case (w_addr_low)
          2'd0: begin w_load_result = {w_load_data[7:0],  w_rt_value[23:0]}; w_rf_we = 4'b1000; end
          2'd1: begin w_load_result = {w_load_data[15:0], w_rt_value[15:0]}; w_rf_we = 4'b1100; end
          2'd2: begin w_load_result = {w_load_data[23:0], w_rt_value[7:0]};  w_rf_we = 4'b1110; end
          default: begin w_load_result = w_load_data; w_rf_we = 4'b1111; end
        endcase
      end
      3'd6: begin
        case (w_addr_low)
          2'd0: begin w_load_result = w_load_data; w_rf_we = 4'b1111; end
          2'd1: begin w_load_result = {w_rt_value[31:24], w_load_data[31:8]};  w_rf_we = 4'b0111; end
          2'd2: begin w_load_result = {w_rt_value[31:16], w_load_data[31:16]}; w_rf_we = 4'b0011; end
          default: begin w_load_result = {w_rt_value[31:8], w_load_data[31:24]}; w_rf_we = 4'b0001; end
        endcase
      end
      default: w_load_result = w_load_data;
    endcase
  end

  logic [31:0]                w_final_result;
  logic [MS_TO_WS_BUS_WD-1:0] w_ms_to_ws_bus;

  assign w_final_result = w_res_from_mem ? w_load_result : w_alu_result;
  assign w_ms_to_ws_bus = {w_pass, w_rf_we, w_dest, w_final_result, w_pc};

  assign ms_if.ms_allowin     = w_allowin;
  assign ms_if.ms_to_ws_valid = r_ms_valid & w_ready_go & ~ms_if.ws_cancel;
  assign ms_if.ms_to_ws_bus   = w_ms_to_ws_bus;
  assign ms_if.ms_fwd_valid   = r_ms_valid & (w_rf_we != 4'd0);
  assign ms_if.ms_fwd_dest    = w_dest;
  assign ms_if.ms_fwd_data    = w_final_result;
  assign ms_if.ms_fwd_blk     = r_ms_valid & (w_res_from_cp0 | (w_res_from_mem & ~w_ready_go));
  assign ms_if.ms_has_ex      = r_ms_valid & (w_ex | w_eret);

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ES_TO_MS_BUS_WD, default 194, width of the execute-to-memory bus.
REQ-002 SHALL have parameter MS_TO_WS_BUS_WD, default 155, width of the memory-to-writeback bus.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 es_to_ms_valid  in  1  upstream instruction valid.
REQ-006 es_to_ms_bus  in  194  fields MSB->LSB: ex[193], exccode[192:188], bd[187], badvaddr[186:155], eret[154], mtc0[153], cp0_addr[152:145], cp0_wdata[144:113], res_from_cp0[112], res_from_mem[111], load_op[110:108], addr_low[107:106], req_issued[105], rt_value[104:73], rf_we[72:69], dest[68:64], alu_result[63:32], pc[31:0].
REQ-007 ms_allowin  out  1  stage may accept a new instruction.
REQ-008 data_sram_data_ok  in  1  load/store response beat.
REQ-009 data_sram_rdata  in  32  load response data, valid with data_ok.
REQ-010 ws_allowin  in  1  downstream accepts.
REQ-011 ws_cancel  in  1  exception/eret flush from writeback.
REQ-012 ms_to_ws_valid  out  1  outgoing instruction valid.
REQ-013 ms_to_ws_bus  out  155  {ex, exccode, bd, badvaddr, eret, mtc0, cp0_addr, cp0_wdata, res_from_cp0, rf_we[3:0], dest, final_result, pc}, same order and widths as the corresponding input fields.
REQ-014 ms_fwd_valid / ms_fwd_dest / ms_fwd_data / ms_fwd_blk  out  1/5/32/1  bypass to decode; blk=1 means the value is not yet usable.
REQ-015 ms_has_ex  out  1  ms_valid & (ex | eret); upstream suppresses stores when it is high.

Function
REQ-016 SHALL latch es_to_ms_bus when es_to_ms_valid & ms_allowin; ms_valid SHALL load es_to_ms_valid when ms_allowin.
REQ-017 ms_ready_go SHALL equal !req_issued | data_got | (data_ok & discard_cnt==0).
REQ-018 ms_allowin SHALL equal !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid SHALL equal ms_valid & ms_ready_go & !ws_cancel.
REQ-019 Data buffer: on data_ok with discard_cnt==0, ms_valid and !data_got, SHALL store rdata in data_buf and set data_got; data_got SHALL clear when the instruction leaves or on ws_cancel.
REQ-020 Load data source SHALL be data_buf when data_got, otherwise data_sram_rdata.
REQ-021 load_op: 0 lw; 1 lb sign-extended; 2 lbu zero-extended; 3 lh sign-extended; 4 lhu zero-extended; byte/half selected by addr_low.
REQ-022 load_op 5 (lwl), addr_low 0..3: rf_we 1000/1100/1110/1111; data {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
REQ-023 load_op 6 (lwr), addr_low 0..3: rf_we 1111/0111/0011/0001; data d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
REQ-024 For non-lwl/lwr instructions, rf_we SHALL pass through unchanged; final_result SHALL be the load result if res_from_mem, else alu_result.
REQ-025 Cancel: on ws_cancel, ms_valid SHALL clear next cycle; if ms_valid & req_issued & !data_got & !data_ok, discard_cnt (2-bit) SHALL increment.
REQ-026 A data_ok arriving while discard_cnt!=0 SHALL decrement discard_cnt and SHALL NOT update data_buf or data_got.
REQ-027 If cancel and data_ok coincide, the beat SHALL be consumed and discarded, and discard_cnt SHALL be unchanged.
REQ-028 ms_fwd_valid SHALL equal ms_valid & (rf_we!=0); ms_fwd_blk SHALL equal ms_valid & (res_from_cp0 | (res_from_mem & !ms_ready_go)).
REQ-029 Exception fields SHALL pass through unmodified; the stage SHALL NOT alter rf_we on exception.

Reset
REQ-030 On reset, ms_valid, data_got and discard_cnt SHALL be 0, and every valid/handshake output SHALL be 0, with ms_allowin=1.
REQ-031 Reset mid-wait SHALL drop the instruction and clear discard_cnt; a data_ok in the first cycle after reset is ignored.

Verification
REQ-032 lw at addr_low 0 with req_issued=1; data_ok arrives 3 cycles later with 0x8765_4321 -> ms_to_ws_valid rises that cycle, final_result=0x87654321, rf_we=1111.
REQ-033 lb at addr_low 3 with rdata 0x80xx_xxxx -> result 0xFFFFFF80; lbu gives 0x00000080.
REQ-034 lwl at addr_low 1 with rt=0xAABBCCDD, rdata=0x11223344 -> result 0x3344CCDD, rf_we=1100.
REQ-035 data_ok while ws_allowin=0, then ws_allowin=1 two cycles later -> buffered data is forwarded and no beat is lost.
REQ-036 ws_cancel while a load is outstanding -> ms_valid=0 and discard_cnt=1; the next data_ok is dropped; a following load receives its own data.
